hja_sw_ctrl: RTL and testbench

Front-panel input controller: the human-to-design path, complementing the switch-selected LED debug display. It synchronises and debounces the 16 DIP switches and two push buttons. It derives the CPU clock-enable for run, single-step and halt modes, and issues debug memory-poke requests with a req/ack handshake. Sits at top level between the board pins and the CPU pipeline or memory arbiter.

---
 rtl/hja_sw_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hja_sw_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hja_sw_ctrl.sv
// hja_sw_ctrl: front-panel input controller (switch/button debounce, CPU run/step/halt enable, debug poke handshake)
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_sw_raw[15:0]        raw DIP switches
//   i_btn_step_raw        raw step button (pressed = 1)
//   i_btn_poke_raw        raw poke button (pressed = 1)
//   i_poke_ack            one-cycle acknowledge from the memory side
//   o_sw[15:0]            debounced switches; o_sw[15:14] selects RUN/STEP/POKE/HALT
//   o_cpu_en              CPU clock-enable
//   o_poke_req            debug write request, high until ack or timeout
//   o_poke_addr/o_poke_data  poke address/data, stable while o_poke_req is high
//   o_status[15:0]        {mode, state, timeout_flag, 3'b0, step_cnt}
module hja_sw_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACK_TIMEOUT     = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_sw_raw,
  input  logic        i_btn_step_raw,
  input  logic        i_btn_poke_raw,
  input  logic        i_poke_ack,
  output logic [15:0] o_sw,
  output logic        o_cpu_en,
  output logic        o_poke_req,
  output logic [15:0] o_poke_addr,
  output logic [15:0] o_poke_data,
  output logic [15:0] o_status
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_POKE = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, HAVE_ADDR = 2'd1, REQ = 2'd2, WAIT_REL = 2'd3} state_t;

  logic [15:0]   r_sw_s1, r_sw_s2, r_sw_prev, r_sw;
  logic [DW-1:0] r_sw_cnt;
  logic [1:0]    w_btn_raw, w_btn_acc, w_btn_press;
  logic [1:0]    w_mode;
  logic          w_in_poke, w_step_go, w_poke_go;
  state_t        r_state, w_state_nxt;
  logic          w_ld_addr, w_ld_data, w_tmo;
  logic [TW-1:0] r_tcnt;
  logic [15:0]   r_addr, r_data;
  logic          r_tflag, r_step_en;
  logic [7:0]    r_step_cnt;

  // Switch vector: one shared counter; any change of the synced vector restarts the count at 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_sw_prev <= '0;
      r_sw      <= '0;
      r_sw_cnt  <= '0;
    end else begin
      r_sw_s1   <= i_sw_raw;
      r_sw_s2   <= r_sw_s1;
      r_sw_prev <= r_sw_s2;
      if (r_sw_s2 == r_sw) r_sw_cnt <= '0;
      else if (r_sw_s2 != r_sw_prev) r_sw_cnt <= D_ONE;
      else if (r_sw_cnt == D_LAST) begin
        r_sw     <= r_sw_s2;
        r_sw_cnt <= '0;
      end else r_sw_cnt <= r_sw_cnt + D_ONE;
    end
  end

  assign w_btn_raw = {i_btn_poke_raw, i_btn_step_raw};

  // Buttons: bit 0 = step, bit 1 = poke; press pulse coincides with the accepted 0->1 change
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          r_s1, r_s2, r_acc, r_press;
    logic [DW-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_acc   <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_btn_raw[b];
        r_s2    <= r_s1;
        r_press <= 1'b0;
        if (r_s2 == r_acc) r_cnt <= '0;
        else if (r_cnt == D_LAST) begin
          r_acc   <= r_s2;
          r_press <= r_s2;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + D_ONE;
      end
    end
    assign w_btn_acc[b]   = r_acc;
    assign w_btn_press[b] = r_press;
  end

  assign w_mode    = r_sw[15:14];
  assign w_in_poke = (w_mode == MODE_POKE);
  assign w_step_go = w_btn_press[0] & (w_mode == MODE_STEP);
  assign w_poke_go = w_btn_press[1] & w_in_poke;

  // A request already in flight ignores mode changes; only HAVE_ADDR is abandoned
  always_comb begin
    w_state_nxt = r_state;
    w_ld_addr   = 1'b0;
    w_ld_data   = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: if (w_poke_go) begin
        w_ld_addr   = 1'b1;
        w_state_nxt = HAVE_ADDR;
      end
      HAVE_ADDR: if (!w_in_poke) w_state_nxt = IDLE;
      else if (w_btn_press[1]) begin
        w_ld_data   = 1'b1;
        w_state_nxt = REQ;
      end
      REQ: if (i_poke_ack) w_state_nxt = WAIT_REL;
      else if (r_tcnt == T_LAST) begin
        w_tmo       = 1'b1;
        w_state_nxt = WAIT_REL;
      end
      WAIT_REL: if (!w_btn_acc[1]) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_tcnt     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_tflag    <= 1'b0;
      r_step_en  <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= (r_state == REQ) ? r_tcnt + T_ONE : '0;
      r_tflag   <= w_tmo | (r_tflag & ~w_ld_data);
      r_step_en <= w_step_go;
      if (w_ld_addr) r_addr <= r_sw;
      if (w_ld_data) r_data <= r_sw;
      if (w_step_go) r_step_cnt <= r_step_cnt + 8'd1;
    end
  end

  // Request is the REQ state itself, so async reset drops it at once
  assign o_poke_req  = (r_state == REQ);
  assign o_cpu_en    = (w_mode == MODE_RUN) | ((w_mode == MODE_STEP) & r_step_en);
  assign o_sw        = r_sw;
  assign o_poke_addr = r_addr;
  assign o_poke_data = r_data;
  assign o_status    = {w_mode, r_state, r_tflag, 3'b000, r_step_cnt};
endmodule

// File: tb/tb_hja_sw_ctrl.sv
// tb_hja_sw_ctrl: self-checking bench for hja_sw_ctrl with a history-based behavioural model
module tb_hja_sw_ctrl;
  localparam int D = 4;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw_raw = '0;
  logic        btn_step_raw = 1'b0, btn_poke_raw = 1'b0, poke_ack = 1'b0;
  logic [15:0] sw, poke_addr, poke_data, status;
  logic        cpu_en, poke_req;

  int total = 0;
  int bad = 0;
  int en_hi = 0;

  hja_sw_ctrl #(.DEBOUNCE_CYCLES(D), .ACK_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(sw_raw),
    .i_btn_step_raw(btn_step_raw), .i_btn_poke_raw(btn_poke_raw), .i_poke_ack(poke_ack),
    .o_sw(sw), .o_cpu_en(cpu_en), .o_poke_req(poke_req),
    .o_poke_addr(poke_addr), .o_poke_data(poke_data), .o_status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: raw history queue; a field is accepted once its synced value (raw delayed 2)
  // has been identical for the last D cycles. Timeout measured as cycles since request start.
  logic [17:0] q[$];
  logic [17:0] r0, ri;
  logic [15:0] m_sw, m_addr, m_data, p_sw;
  logic        m_sacc, m_pacc, m_spress, m_ppress, m_step_en, m_tflag;
  logic        p_sp, p_pp, p_pacc, st_sw, st_s, st_p;
  logic [7:0]  m_scnt;
  int          m_state, p_st, m_cyc, m_start;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < D + 2; i++) q.push_back(18'd0);
      m_sw = '0; m_addr = '0; m_data = '0;
      m_sacc = 0; m_pacc = 0; m_spress = 0; m_ppress = 0; m_step_en = 0; m_tflag = 0;
      m_scnt = '0; m_state = 0; m_cyc = 0; m_start = 0;
    end else begin
      p_sw = m_sw; p_sp = m_spress; p_pp = m_ppress; p_pacc = m_pacc; p_st = m_state;
      m_cyc++;
      q.push_back({btn_poke_raw, btn_step_raw, sw_raw});
      void'(q.pop_front());
      r0 = q[0];
      st_sw = 1; st_s = 1; st_p = 1;
      for (int i = 1; i < D; i++) begin
        ri = q[i];
        if (ri[15:0] != r0[15:0]) st_sw = 0;
        if (ri[16] != r0[16]) st_s = 0;
        if (ri[17] != r0[17]) st_p = 0;
      end
      if (st_sw) m_sw = r0[15:0];
      m_spress = st_s && r0[16] && !m_sacc;
      if (st_s) m_sacc = r0[16];
      m_ppress = st_p && r0[17] && !m_pacc;
      if (st_p) m_pacc = r0[17];
      m_step_en = p_sp && (p_sw[15:14] == 2'b01);
      if (m_step_en) m_scnt++;
      case (p_st)
        0: if (p_pp && p_sw[15:14] == 2'b10) begin m_addr = p_sw; m_state = 1; end
        1: if (p_sw[15:14] != 2'b10) m_state = 0;
           else if (p_pp) begin m_data = p_sw; m_tflag = 0; m_start = m_cyc; m_state = 2; end
        2: if (poke_ack) m_state = 3;
           else if (m_cyc - m_start == T) begin m_tflag = 1; m_state = 3; end
        default: if (!p_pacc) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [1:0] ms;
    logic       ee;
    ms = m_state[1:0];
    ee = (m_sw[15:14] == 2'b00) || (m_sw[15:14] == 2'b01 && m_step_en);
    chk("m_sw", sw, m_sw);
    chk("m_cpu_en", {15'd0, cpu_en}, {15'd0, ee});
    chk("m_poke_req", {15'd0, poke_req}, {15'd0, m_state == 2});
    chk("m_poke_addr", poke_addr, m_addr);
    chk("m_poke_data", poke_data, m_data);
    chk("m_status", status, {m_sw[15:14], ms, m_tflag, 3'b000, m_scnt});
    if (cpu_en) en_hi++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_poke();
    btn_poke_raw = 1; cyc(8);
    btn_poke_raw = 0; cyc(8);
  endtask

  task automatic press_step();
    btn_step_raw = 1; cyc(8);
    btn_step_raw = 0; cyc(8);
  endtask

  task automatic wait_req();
    logic ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc(1);
      if (poke_req) ok = 1;
    end
    chk("req_rise", {15'd0, ok}, 16'd1);
  endtask

  initial begin
    int n;
    repeat (4) begin
      @(negedge clk);
      sw_raw = 16'($urandom); btn_step_raw = 1'($urandom); btn_poke_raw = 1'($urandom);
    end
    chk("rst_sw", sw, 16'h0000);
    chk("rst_cpu_en", {15'd0, cpu_en}, 16'd1);
    chk("rst_req", {15'd0, poke_req}, 16'd0);
    chk("rst_status", status, 16'h0000);
    @(negedge clk);
    sw_raw = 0; btn_step_raw = 0; btn_poke_raw = 0; rst_n = 1;
    cyc(1);
    chk("en_after_rst", {15'd0, cpu_en}, 16'd1);

    sw_raw = 16'h4000;
    cyc(5); chk("sw_early", sw, 16'h0000);
    cyc(1); chk("sw_step", sw, 16'h4000);
    chk("step_en_idle", {15'd0, cpu_en}, 16'd0);
    cyc(2);
    en_hi = 0;
    repeat (3) press_step();
    chk("step_pulses", 16'(en_hi), 16'd3);
    chk("step_cnt3", {8'd0, status[7:0]}, 16'd3);

    @(posedge clk); #2 rst_n = 0;
    cyc(2); rst_n = 1;
    cyc(8);
    en_hi = 0;
    for (int i = 0; i < 10; i++) begin
      btn_step_raw = ~btn_step_raw; cyc(2);
    end
    btn_step_raw = 1;
    cyc(6); chk("bounce_pre", {15'd0, cpu_en}, 16'd0);
    cyc(1); chk("bounce_pulse", {15'd0, cpu_en}, 16'd1);
    cyc(1); chk("bounce_post", {15'd0, cpu_en}, 16'd0);
    cyc(6);
    chk("bounce_once", 16'(en_hi), 16'd1);
    chk("bounce_cnt", {8'd0, status[7:0]}, 16'd1);
    btn_step_raw = 0; cyc(8);

    sw_raw = 16'h8123; cyc(8);
    chk("poke_en", {15'd0, cpu_en}, 16'd0);
    press_poke();
    chk("have_addr", {14'd0, status[13:12]}, 16'd1);
    sw_raw = 16'h80AB; cyc(8);
    btn_poke_raw = 1;
    wait_req();
    chk("poke_addr", poke_addr, 16'h8123);
    chk("poke_data", poke_data, 16'h80AB);
    cyc(3); poke_ack = 1;
    cyc(1); poke_ack = 0;
    chk("ack_drop", {15'd0, poke_req}, 16'd0);
    chk("wait_rel", {14'd0, status[13:12]}, 16'd3);
    cyc(3); chk("wait_rel_hold", {14'd0, status[13:12]}, 16'd3);
    btn_poke_raw = 0; cyc(8);
    chk("back_idle", {14'd0, status[13:12]}, 16'd0);
    poke_ack = 1; cyc(1); poke_ack = 0; cyc(2);
    chk("stray_ack", {14'd0, status[13:12]}, 16'd0);

    sw_raw = 16'h8123; cyc(8);
    press_poke();
    sw_raw = 16'h80AB; cyc(8);
    btn_poke_raw = 1;
    wait_req();
    n = 0;
    while (poke_req && n < 20) begin n++; cyc(1); end
    chk("tmo_len", 16'(n), 16'd8);
    chk("tmo_flag", {15'd0, status[11]}, 16'd1);
    btn_poke_raw = 0; cyc(8);

    press_poke();
    chk("mc_have_addr", {14'd0, status[13:12]}, 16'd1);
    sw_raw = 16'h0000; cyc(8);
    chk("mc_idle", {14'd0, status[13:12]}, 16'd0);
    chk("mc_noreq", {15'd0, poke_req}, 16'd0);
    sw_raw = 16'h8123; cyc(8);
    press_poke();
    btn_poke_raw = 1;
    wait_req();
    sw_raw = 16'hC000;
    cyc(6);
    chk("halt_req_held", {15'd0, poke_req}, 16'd1);
    chk("halt_mode", {14'd0, status[15:14]}, 16'd3);
    chk("halt_en", {15'd0, cpu_en}, 16'd0);
    poke_ack = 1; cyc(1); poke_ack = 0;
    chk("halt_ack_drop", {15'd0, poke_req}, 16'd0);
    chk("halt_noflag", {15'd0, status[11]}, 16'd0);
    btn_poke_raw = 0; cyc(8);

    sw_raw = 16'h8123; cyc(8);
    press_poke();
    btn_poke_raw = 1;
    wait_req();
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("arst_req", {15'd0, poke_req}, 16'd0);
    chk("arst_addr", poke_addr, 16'h0000);
    btn_poke_raw = 0;
    @(negedge clk); rst_n = 1;
    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
